// File: rtl/booth_multiplier_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// FSM state encodings, adder select constants and the fixed operand width.
package booth_multiplier_ctrl_pkg;

  localparam int MULT_WIDTH = 32;

  // sel0 values understood by multiplier_adder
  localparam logic BOOTH_ADD = 1'b1;
  localparam logic BOOTH_SUB = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiplier_adder.sv
// 32-bit add/subtract/pass unit used by the Booth controller.
// sel0 chooses a+b or a-b; sel1 chooses the arithmetic result or passes a.
module multiplier_adder
  import booth_multiplier_ctrl_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] a,
  input  logic [MULT_WIDTH-1:0] b,
  input  logic                  sel0,
  input  logic                  sel1,
  output logic [MULT_WIDTH-1:0] out
);

  logic [MULT_WIDTH-1:0] sum;

  // Select the arithmetic operation, then choose between it and a pass of a
  always_comb begin
    sum = (sel0 == BOOTH_ADD) ? (a + b) : (a - b);
    out = sel1 ? sum : a;
  end

endmodule

// File: rtl/booth_multiplier_ctrl.sv
// Sequential radix-2 Booth controller: signed 32x32 -> 64 multiply, one
// add/sub/pass plus one arithmetic right shift of {A,Q,q_m1} per cycle.
// Product registers only update on completion, so partial values never leak.
module booth_multiplier_ctrl
  import booth_multiplier_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;      // A: upper half of the partial product
  logic [WIDTH-1:0] q_reg;    // Q: multiplier being consumed, fills with low product bits
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;    // M: latched multiplicand

  logic             sel0;
  logic             sel1;
  logic [WIDTH-1:0] r;
  logic             ovf;
  logic             shift_in;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;

  multiplier_adder u_adder (
    .a    (acc),
    .b    (m_reg),
    .sel0 (sel0),
    .sel1 (sel1),
    .out  (r)
  );

  // Booth recoding of the current bit pair into adder selects
  always_comb begin
    sel0 = BOOTH_ADD;
    sel1 = 1'b0;
    case ({q_reg[0], q_m1})
      2'b01: begin sel1 = 1'b1; sel0 = BOOTH_ADD; end
      2'b10: begin sel1 = 1'b1; sel0 = BOOTH_SUB; end
      default: begin sel1 = 1'b0; sel0 = BOOTH_ADD; end
    endcase
  end

  // Recover the true 33rd sign bit when the step overflows, then form the shifted values
  always_comb begin
    ovf = 1'b0;
    if (sel1) begin
      if (sel0 == BOOTH_ADD)
        ovf = (acc[WIDTH-1] == m_reg[WIDTH-1]) && (r[WIDTH-1] != acc[WIDTH-1]);
      else
        ovf = (acc[WIDTH-1] != m_reg[WIDTH-1]) && (r[WIDTH-1] != acc[WIDTH-1]);
    end
    shift_in = ovf ? acc[WIDTH-1] : r[WIDTH-1];
    acc_next = {shift_in, r[WIDTH-1:1]};
    q_next   = {r[0], q_reg[WIDTH-1:1]};
  end

  // Control FSM, iteration counter, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      count      <= '0;
      acc        <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      m_reg      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          q_reg <= q_next;
          q_m1  <= q_reg[0];
          count <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            product_hi <= acc_next;
            product_lo <= q_next;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
